// File: rtl/micro_sequencer.sv
// Microprogram sequencer: 16-instruction next-address logic with subroutine/loop stack,
// loop counter, R register and conditional-test mux driving the microcode ROM address.
module micro_sequencer #(
    parameter int AW          = 11,
    parameter int STACK_DEPTH = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [3:0]    instr,
    input  logic [AW-1:0] d_in,
    input  logic [AW-1:0] map_in,
    input  logic [AW-1:0] vector_in,
    input  logic          cc,
    input  logic          cc_polarity,
    input  logic          cc_enable,
    input  logic          load_r,
    input  logic          incr,
    output logic [AW-1:0] y_out,
    output logic          map_sel,
    output logic          vect_sel,
    output logic          counter_zero,
    output logic          stack_empty,
    output logic          stack_full,
    output logic          stack_overflow,
    output logic          stack_underflow
);

    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SPW-1:0] SP_ZERO = SPW'(0);
    localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);
    localparam logic [AW-1:0]  A_ZERO  = AW'(0);
    localparam logic [AW-1:0]  A_ONE   = AW'(1);

    typedef enum logic [3:0] {
        I_JZ   = 4'd0,  I_CJS  = 4'd1,  I_JMAP = 4'd2,  I_CJP  = 4'd3,
        I_PUSH = 4'd4,  I_JSRP = 4'd5,  I_CJV  = 4'd6,  I_JRP  = 4'd7,
        I_RFCT = 4'd8,  I_RPCT = 4'd9,  I_CRTN = 4'd10, I_CJPP = 4'd11,
        I_LDCT = 4'd12, I_LOOP = 4'd13, I_CONT = 4'd14, I_TWB  = 4'd15
    } instr_e;

    logic [AW-1:0]  upc_q, upc_d;
    logic [AW-1:0]  r_q, r_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  stack_q [STACK_DEPTH];
    logic [AW-1:0]  stack_d [STACK_DEPTH];
    logic [SPW-1:0] sp_q, sp_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;

    logic           pass_s;
    logic           cnt_nz_s;
    logic [AW-1:0]  tos_s;
    logic [AW-1:0]  y_s;
    logic           map_s, vect_s;
    logic           push_s, pop_s, dec_s, ld_cnt_s, clr_sp_s;
    logic [SIW-1:0] tos_idx_s, push_idx_s;

    // Condition test and top-of-stack view (empty stack reads as zero)
    always_comb begin
        pass_s     = ~cc_enable | (cc ^ cc_polarity);
        cnt_nz_s   = (cnt_q != A_ZERO);
        tos_idx_s  = SIW'(sp_q - SP_ONE);
        push_idx_s = SIW'(sp_q);
        if (sp_q == SP_ZERO) begin
            tos_s = A_ZERO;
        end else begin
            tos_s = stack_q[tos_idx_s];
        end
    end

    // Next-address select and per-instruction side-effect strobes
    always_comb begin
        y_s      = upc_q;
        map_s    = 1'b0;
        vect_s   = 1'b0;
        push_s   = 1'b0;
        pop_s    = 1'b0;
        dec_s    = 1'b0;
        ld_cnt_s = 1'b0;
        clr_sp_s = 1'b0;
        case (instr_e'(instr))
            I_JZ: begin
                y_s      = A_ZERO;
                clr_sp_s = 1'b1;
            end
            I_CJS: begin
                if (pass_s) begin
                    y_s    = d_in;
                    push_s = 1'b1;
                end else begin
                    y_s = upc_q;
                end
            end
            I_JMAP: begin
                y_s   = map_in;
                map_s = 1'b1;
            end
            I_CJP:  y_s = pass_s ? d_in : upc_q;
            I_PUSH: begin
                push_s   = 1'b1;
                ld_cnt_s = pass_s;
            end
            I_JSRP: begin
                push_s = 1'b1;
                y_s    = pass_s ? d_in : r_q;
            end
            I_CJV: begin
                vect_s = 1'b1;
                y_s    = pass_s ? vector_in : upc_q;
            end
            I_JRP:  y_s = pass_s ? d_in : r_q;
            I_RFCT: begin
                if (cnt_nz_s) begin
                    y_s   = tos_s;
                    dec_s = 1'b1;
                end else begin
                    pop_s = 1'b1;
                end
            end
            I_RPCT: begin
                if (cnt_nz_s) begin
                    y_s   = d_in;
                    dec_s = 1'b1;
                end else begin
                    y_s = upc_q;
                end
            end
            I_CRTN: begin
                if (pass_s) begin
                    y_s   = tos_s;
                    pop_s = 1'b1;
                end else begin
                    y_s = upc_q;
                end
            end
            I_CJPP: begin
                if (pass_s) begin
                    y_s   = d_in;
                    pop_s = 1'b1;
                end else begin
                    y_s = upc_q;
                end
            end
            I_LDCT: ld_cnt_s = 1'b1;
            I_LOOP: begin
                if (pass_s) begin
                    pop_s = 1'b1;
                end else begin
                    y_s = tos_s;
                end
            end
            I_CONT: y_s = upc_q;
            I_TWB: begin
                if (pass_s) begin
                    pop_s = 1'b1;
                end else if (cnt_nz_s) begin
                    y_s   = tos_s;
                    dec_s = 1'b1;
                end else begin
                    y_s   = d_in;
                    pop_s = 1'b1;
                end
            end
            default: y_s = upc_q;
        endcase
    end

    // Next-state for uPC, R, counter, stack pointer/contents and sticky flags
    always_comb begin
        upc_d   = y_s + {{(AW-1){1'b0}}, incr};
        r_d     = load_r ? d_in : r_q;
        stack_d = stack_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (ld_cnt_s) begin
            cnt_d = d_in;
        end else if (dec_s && cnt_nz_s) begin
            cnt_d = cnt_q - A_ONE;
        end else begin
            cnt_d = cnt_q;
        end
        if (clr_sp_s) begin
            sp_d  = SP_ZERO;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (push_s) begin
            if (sp_q == SP_FULL) begin
                ovf_d = 1'b1;
            end else begin
                stack_d[push_idx_s] = upc_q;
                sp_d                = sp_q + SP_ONE;
            end
        end else if (pop_s) begin
            if (sp_q == SP_ZERO) begin
                unf_d = 1'b1;
            end else begin
                sp_d = sp_q - SP_ONE;
            end
        end else begin
            sp_d = sp_q;
        end
    end

    // State registers; reset discards everything immediately
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            upc_q <= A_ZERO;
            r_q   <= A_ZERO;
            cnt_q <= A_ZERO;
            sp_q  <= SP_ZERO;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= A_ZERO;
            end
        end else begin
            upc_q   <= upc_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            stack_q <= stack_d;
        end
    end

    // ROM address is combinational so the fetch happens in the same cycle
    always_comb begin
        if (reset) begin
            y_out    = y_s;
            map_sel  = map_s;
            vect_sel = vect_s;
        end else begin
            y_out    = A_ZERO;
            map_sel  = 1'b0;
            vect_sel = 1'b0;
        end
        counter_zero    = (cnt_q == A_ZERO);
        stack_empty     = (sp_q == SP_ZERO);
        stack_full      = (sp_q == SP_FULL);
        stack_overflow  = ovf_q;
        stack_underflow = unf_q;
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: queue-based reference model checked every cycle,
// plus hand-computed address expectations along the stimulus sequence.
module tb_micro_sequencer;

    localparam int AW = 11;
    localparam int SD = 8;
    localparam int unsigned MASK = (32'd1 << AW) - 32'd1;

    logic          clock = 1'b0;
    logic          reset;
    logic [3:0]    instr;
    logic [AW-1:0] d_in, map_in, vector_in;
    logic          cc, cc_polarity, cc_enable, load_r, incr;
    logic [AW-1:0] y_out;
    logic          map_sel, vect_sel, counter_zero, stack_empty, stack_full;
    logic          stack_overflow, stack_underflow;

    micro_sequencer #(.AW(AW), .STACK_DEPTH(SD)) dut (
        .clock(clock), .reset(reset), .instr(instr), .d_in(d_in), .map_in(map_in),
        .vector_in(vector_in), .cc(cc), .cc_polarity(cc_polarity), .cc_enable(cc_enable),
        .load_r(load_r), .incr(incr), .y_out(y_out), .map_sel(map_sel), .vect_sel(vect_sel),
        .counter_zero(counter_zero), .stack_empty(stack_empty), .stack_full(stack_full),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    int unsigned m_upc, m_r, m_cnt;
    int unsigned m_stk[$];
    bit m_ovf, m_unf;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        m_upc = 0; m_r = 0; m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
        m_stk.delete();
    endfunction

    function automatic bit m_pass();
        return !cc_enable || (cc != cc_polarity);
    endfunction

    function automatic int unsigned m_tos();
        return (m_stk.size() == 0) ? 0 : m_stk[$];
    endfunction

    // Address the sequencer must present, grouped by instruction shape
    function automatic int unsigned m_target();
        bit p = m_pass();
        if (!reset) return 0;
        case (instr)
            4'd0:              return 0;
            4'd1, 4'd3, 4'd11: return p ? d_in : m_upc;
            4'd2:              return map_in;
            4'd4, 4'd12, 4'd14: return m_upc;
            4'd5, 4'd7:        return p ? d_in : m_r;
            4'd6:              return p ? vector_in : m_upc;
            4'd8:              return (m_cnt != 0) ? m_tos() : m_upc;
            4'd9:              return (m_cnt != 0) ? d_in : m_upc;
            4'd10:             return p ? m_tos() : m_upc;
            4'd13:             return p ? m_upc : m_tos();
            default:           return p ? m_upc : ((m_cnt != 0) ? m_tos() : d_in);
        endcase
    endfunction

    function automatic void m_advance();
        int unsigned y;
        bit p, do_push, do_pop, do_dec, do_ld;
        if (!reset) return;
        y = m_target();
        p = m_pass();
        do_push = (instr == 4'd4) || (instr == 4'd5) || (instr == 4'd1 && p);
        do_pop  = (instr == 4'd8 && m_cnt == 0) || ((instr == 4'd10 || instr == 4'd11) && p)
               || (instr == 4'd13 && p) || (instr == 4'd15 && (p || m_cnt == 0));
        do_dec  = ((instr == 4'd8 || instr == 4'd9) && m_cnt != 0)
               || (instr == 4'd15 && m_cnt != 0 && !p);
        do_ld   = (instr == 4'd12) || (instr == 4'd4 && p);
        if (instr == 4'd0) begin
            m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end
        if (do_push) begin
            if (m_stk.size() == SD) m_ovf = 1'b1;
            else m_stk.push_back(m_upc);
        end
        if (do_pop) begin
            if (m_stk.size() == 0) m_unf = 1'b1;
            else void'(m_stk.pop_back());
        end
        if (do_ld) m_cnt = d_in;
        else if (do_dec && m_cnt != 0) m_cnt = m_cnt - 1;
        if (load_r) m_r = d_in;
        m_upc = (y + incr) & MASK;
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            chk("y_out", y_out, m_target());
            chk("map_sel", map_sel, reset && instr == 4'd2);
            chk("vect_sel", vect_sel, reset && instr == 4'd6);
            chk("counter_zero", counter_zero, m_cnt == 0);
            chk("stack_empty", stack_empty, m_stk.size() == 0);
            chk("stack_full", stack_full, m_stk.size() == SD);
            chk("stack_overflow", stack_overflow, m_ovf);
            chk("stack_underflow", stack_underflow, m_unf);
        end
    end

    task automatic step();
        @(posedge clock);
        m_advance();
        #1;
    endtask

    task automatic op(input logic [3:0] i, input logic [AW-1:0] d, input bit p);
        instr = i; d_in = d; cc_enable = 1'b1; cc = p; cc_polarity = 1'b0;
    endtask

    initial begin
        reset = 1'b0; instr = 4'd14; d_in = '0; map_in = '0; vector_in = '0;
        cc = 1'b0; cc_polarity = 1'b0; cc_enable = 1'b0; load_r = 1'b0; incr = 1'b1;
        m_reset();
        chk_en = 1'b1;
        @(negedge clock);
        chk("rst_y", y_out, 0); chk("rst_cz", counter_zero, 1); chk("rst_se", stack_empty, 1);
        step(); step();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock); chk("count_y", y_out, k); step();
        end
        incr = 1'b0;
        repeat (2) begin @(negedge clock); chk("hold_y", y_out, 4); step(); end
        incr = 1'b1;
        op(4'd3, 11'h010, 1'b1); @(negedge clock); chk("cjp_y", y_out, 11'h010); step();
        op(4'd1, 11'h200, 1'b1); @(negedge clock); chk("cjs_y", y_out, 11'h200); step();
        op(4'd10, 11'h000, 1'b1); @(negedge clock); chk("crtn_y", y_out, 11'h011); step();
        op(4'd14, 11'h000, 1'b1); @(negedge clock); chk("crtn_empty", stack_empty, 1); step();
        // counted loop: body at 0x021 runs four times
        op(4'd12, 11'h003, 1'b1); step();
        op(4'd3, 11'h020, 1'b1); step();
        op(4'd4, 11'h003, 1'b0); @(negedge clock); chk("push_y", y_out, 11'h021); step();
        for (int k = 0; k < 3; k++) begin
            op(4'd8, 11'h000, 1'b1); @(negedge clock); chk("rfct_loop_y", y_out, 11'h021); step();
        end
        op(4'd8, 11'h000, 1'b1); @(negedge clock);
        chk("rfct_exit_y", y_out, 11'h022); chk("rfct_exit_cz", counter_zero, 1); step();
        op(4'd14, 11'h000, 1'b1); @(negedge clock); chk("loop_done_se", stack_empty, 1); step();
        map_in = 11'h101; op(4'd2, 11'h000, 1'b1); @(negedge clock);
        chk("jmap_y", y_out, 11'h101); chk("jmap_sel", map_sel, 1); step();
        vector_in = 11'h3AA; instr = 4'd6; cc_enable = 1'b1; cc = 1'b1; cc_polarity = 1'b1;
        @(negedge clock); chk("cjv_fail_y", y_out, 11'h102); chk("cjv_vsel", vect_sel, 1); step();
        // overflow: one more push than the stack holds
        for (int k = 0; k < SD + 1; k++) begin op(4'd4, 11'h000, 1'b0); step(); end
        op(4'd13, 11'h000, 1'b0); @(negedge clock);
        chk("ovf_full", stack_full, 1); chk("ovf_flag", stack_overflow, 1); chk("ovf_tos", y_out, 11'h10A); step();
        op(4'd0, 11'h000, 1'b1); @(negedge clock); chk("jz_y", y_out, 0); step();
        op(4'd14, 11'h000, 1'b1); @(negedge clock);
        chk("jz_full", stack_full, 0); chk("jz_ovf", stack_overflow, 0); step();
        op(4'd10, 11'h000, 1'b1); @(negedge clock); chk("crtn_empty_y", y_out, 0); step();
        op(4'd14, 11'h000, 1'b1); @(negedge clock); chk("unf_flag", stack_underflow, 1); step();
        // R register: JRP sees the old R in the cycle that reloads it
        load_r = 1'b1; op(4'd14, 11'h055, 1'b1); step();
        op(4'd7, 11'h066, 1'b0); @(negedge clock); chk("jrp_old_r", y_out, 11'h055); step();
        load_r = 1'b0; op(4'd7, 11'h000, 1'b0); @(negedge clock); chk("jrp_new_r", y_out, 11'h066); step();
        op(4'd5, 11'h300, 1'b1); @(negedge clock); chk("jsrp_y", y_out, 11'h300); step();
        op(4'd11, 11'h400, 1'b1); @(negedge clock); chk("cjpp_y", y_out, 11'h400); step();
        op(4'd12, 11'h001, 1'b1); step();
        op(4'd9, 11'h500, 1'b1); @(negedge clock); chk("rpct_take", y_out, 11'h500); step();
        op(4'd9, 11'h500, 1'b1); @(negedge clock); chk("rpct_fall", y_out, 11'h501); step();
        op(4'd4, 11'h002, 1'b1); step();
        op(4'd15, 11'h600, 1'b0); @(negedge clock); chk("twb_tos1", y_out, 11'h502); step();
        op(4'd15, 11'h600, 1'b0); @(negedge clock); chk("twb_tos2", y_out, 11'h502); step();
        op(4'd15, 11'h600, 1'b0); @(negedge clock); chk("twb_d", y_out, 11'h600); step();
        op(4'd15, 11'h600, 1'b1); @(negedge clock); chk("twb_pass", y_out, 11'h601); step();
        // reset in mid-sequence clears stack and counter immediately
        op(4'd4, 11'h005, 1'b1); step();
        op(4'd14, 11'h000, 1'b1); #2; reset = 1'b0; m_reset();
        @(negedge clock);
        chk("midrst_y", y_out, 0); chk("midrst_se", stack_empty, 1); chk("midrst_cz", counter_zero, 1);
        step(); step();
        reset = 1'b1; @(negedge clock); chk("rel_y", y_out, 0); step();
        op(4'd3, 11'h7FF, 1'b1); @(negedge clock); chk("top_y", y_out, 11'h7FF); step();
        op(4'd14, 11'h000, 1'b1); @(negedge clock); chk("wrap_y", y_out, 0); step();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
